// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding, handshake levels,
// step count and the operand magnitude helper.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [5:0]  DivSteps          = 6'd32;

  // Two's-complement magnitude when the operand is treated as signed and is negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    mag32 = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    neg_if = neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor over 33 bits and keep the difference if it did not borrow.
module div_sub_stage
  import div_seq_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic        msb_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] partial;
  logic [32:0] trial;

  // partial stays below 2*divisor, so a non-negative difference always fits in 32 bits.
  always_comb begin
    partial = {rem_i, msb_i};
    trial   = partial - {1'b0, divisor_i};
    q_bit_o = ~trial[32];
    rem_o   = q_bit_o ? trial[31:0] : partial[31:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit divider (DIV/DIVU), one restoring step per clock, result {HI=rem, LO=quo}.
// Build option: DIV_EARLY_ZERO_EN sends a zero dividend down the 1-clock zero-result path.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  div_state_e  state_next;
  logic [5:0]  cnt;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [63:0] result_q;
  logic [31:0] rem_step;
  logic        q_bit;
  logic        accept;
  logic        zero_req;
  logic        steps_done;

  assign accept     = (start_i == DivStart) && !annul_i;
  assign steps_done = (cnt == DivSteps);

`ifdef DIV_EARLY_ZERO_EN
  assign zero_req = (opdata2_i == ZeroWord) || (opdata1_i == ZeroWord);
`else
  assign zero_req = (opdata2_i == ZeroWord);
`endif

  div_sub_stage u_sub (
    .rem_i     (rem_q),
    .msb_i     (quo_q[31]),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .q_bit_o   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_FREE:    if (accept) state_next = zero_req ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_next = annul_i ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (annul_i)         state_next = DIV_FREE;
        else if (steps_done) state_next = DIV_END;
      end
      DIV_END:     if (start_i == DivStop) state_next = DIV_FREE;
      default:     state_next = DIV_FREE;
    endcase
  end

  // Dividend magnitude is shifted out of quo_q's MSB while quotient bits enter at its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 6'd0;
      quo_q     <= ZeroWord;
      rem_q     <= ZeroWord;
      dvs_q     <= ZeroWord;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {ZeroWord, ZeroWord};
    end else begin
      case (state)
        DIV_FREE: begin
          if (accept) begin
            quo_q     <= mag32(opdata1_i, signed_div_i);
            dvs_q     <= mag32(opdata2_i, signed_div_i);
            rem_q     <= ZeroWord;
            cnt       <= 6'd0;
            neg_quo_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_q <= signed_div_i && opdata1_i[31];
          end
        end
        DIV_BY_ZERO: begin
          result_q <= {ZeroWord, ZeroWord};
          cnt      <= 6'd0;
        end
        DIV_ON: begin
          if (annul_i) begin
            cnt <= 6'd0;
          end else if (!steps_done) begin
            rem_q <= rem_step;
            quo_q <= {quo_q[30:0], q_bit};
            cnt   <= cnt + 6'd1;
          end else begin
            result_q <= {neg_if(rem_q, neg_rem_q), neg_if(quo_q, neg_quo_q)};
            cnt      <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready_o  = DivResultNotReady;
    result_o = {ZeroWord, ZeroWord};
    if (state == DIV_END) begin
      ready_o  = DivResultReady;
      result_o = result_q;
    end
  end

endmodule
